serial_bcd_add_ctrl: RTL

//   Sequences one shared single-digit BCD adder across a multi-digit packed-BCD operand

---
 rtl/bcd_pkg.sv | 8 +
 rtl/bcd_digit_add.sv | 23 ++
 rtl/serial_bcd_add_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the serial packed-BCD adder controller.
package bcd_pkg;
    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder; decimal correction is applied to any sum above 9,
// including sums formed from invalid (>9) digits.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);
    logic [DIGIT_W:0] t;

    always_comb begin
        t    = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        s    = t[DIGIT_W-1:0];
        cout = 1'b0;
        if (t > {1'b0, BCD_MAX}) begin
            s    = t[DIGIT_W-1:0] + BCD_CORR;
            cout = 1'b1;
        end
    end
endmodule

// File: rtl/serial_bcd_add_ctrl.sv
// Time-shares one bcd_digit_add across DIGITS packed-BCD digits, LSD first, one digit per clock.
// Handshake: Start is accepted only on an edge where Busy==0; Done pulses for one cycle with Sum valid.
module serial_bcd_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    input  logic                        Start,
    input  logic [DIGIT_W*DIGITS-1:0]   A,
    input  logic [DIGIT_W*DIGITS-1:0]   B,
    input  logic                        Carry_in,
    output logic                        Busy,
    output logic                        Done,
    output logic [DIGIT_W*DIGITS-1:0]   Sum,
    output logic                        Carry_out,
    output logic                        Invalid,
    output state_t                      state_dbg
);
    localparam int W  = DIGIT_W * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t               state, state_next;
    logic [W-1:0]         a_reg, b_reg, work, work_next;
    logic [CW-1:0]        cnt;
    logic                 carry, sticky;
    logic [DIGIT_W-1:0]   dig_a, dig_b, dig_s;
    logic                 dig_c, digit_bad, last;

    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CW'(i)) begin
                dig_a = a_reg[i*DIGIT_W +: DIGIT_W];
                dig_b = b_reg[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    bcd_digit_add u_digit (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry),
        .s    (dig_s),
        .cout (dig_c)
    );

    always_comb begin
        work_next = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CW'(i)) work_next[i*DIGIT_W +: DIGIT_W] = dig_s;
        end
    end

    assign digit_bad = (dig_a > BCD_MAX) || (dig_b > BCD_MAX);
    assign last      = (cnt == CW'(DIGITS - 1));

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b1;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) state_next = ADD;
            end
            ADD:  if (last) state_next = DONE;
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign state_dbg = state;

    // Result registers load on the edge that leaves ADD, so they change in the same cycle Done is high.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            work      <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            sticky    <= 1'b0;
            Sum       <= '0;
            Carry_out <= 1'b0;
            Invalid   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    a_reg  <= A;
                    b_reg  <= B;
                    carry  <= Carry_in;
                    cnt    <= '0;
                    work   <= '0;
                    sticky <= 1'b0;
                end
                ADD: begin
                    work   <= work_next;
                    carry  <= dig_c;
                    sticky <= sticky | digit_bad;
                    if (last) begin
                        Sum       <= work_next;
                        Carry_out <= dig_c;
                        Invalid   <= sticky | digit_bad;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
